// File: rtl/drain_word_packer.sv
// Packs the drain reader's byte stream into tagged accumulator words and queues them for writeback.
// Word enters the FIFO one edge after its last byte; data_req drops while the FIFO has under two free slots.

module drain_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module drain_word_packer #(
  parameter int ALPHA         = 4,
  parameter int ADD_DATAWIDTH = 16,
  parameter int X_SCALED      = 8,
  parameter int Y_SCALED      = 8,
  parameter int WFIFO_DEPTH   = 4,
  localparam int W  = ALPHA*ADD_DATAWIDTH,
  localparam int RW = $clog2(X_SCALED),
  localparam int CW = $clog2(Y_SCALED)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          drain_start,
  output logic          data_req,
  input  logic [7:0]    data_in,
  input  logic          data_valid,
  input  logic          transfer_complete,
  output logic [W-1:0]  out_word,
  output logic [CW-1:0] out_col,
  output logic [RW-1:0] out_row,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          err_short,
  output logic          err_overflow
);
  localparam int BPW   = W/8;
  localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TOTAL = X_SCALED*Y_SCALED;
  localparam int WCW   = $clog2(TOTAL+1);
  localparam int FW    = 1 + RW + CW + W;
  localparam int CNTW  = $clog2(WFIFO_DEPTH) + 1;

  localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BPW-1);
  localparam logic [WCW-1:0]  TOTAL_C   = WCW'(TOTAL);
  localparam logic [RW-1:0]   ROW_MAX   = RW'(X_SCALED-1);
  localparam logic [CW-1:0]   COL_MAX   = CW'(Y_SCALED-1);
  localparam logic [CNTW-1:0] REQ_LIMIT = CNTW'(WFIFO_DEPTH-2);

  typedef enum logic [1:0] {IDLE, REQ, FLUSH, DONE} state_t;
  state_t state, state_nx;

  logic [W-1:0]    asm_q;
  logic [BCW-1:0]  byte_cnt;
  logic [WCW-1:0]  word_cnt;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   col_q;
  logic            pend_vld;
  logic [FW-1:0]   pend_dat;
  logic            err_short_q;
  logic            err_ovf_q;

  logic [W-1:0]    asm_nx;
  logic            accept;
  logic            word_cmpl;
  logic            tc_req;
  logic            partial;
  logic            new_word;
  logic            new_last;
  logic [WCW-1:0]  word_cnt_nx;
  logic            tile_end;
  logic            short_hit;
  logic            start_tile;

  logic [FW-1:0]   fifo_head;
  logic [CNTW-1:0] fifo_cnt;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fifo_push;
  logic            fifo_pop;
  logic            drop;

  always_comb begin
    asm_nx      = asm_q;
    accept      = (state == REQ) && data_valid;
    word_cmpl   = accept && (byte_cnt == LAST_BYTE);
    tc_req      = (state == REQ) && transfer_complete;
    // The byte arriving with transfer_complete is folded in before the padding decision.
    partial     = tc_req && !word_cmpl && (accept || (byte_cnt != '0));
    new_word    = word_cmpl || partial;
    new_last    = partial || ((row_q == ROW_MAX) && (col_q == COL_MAX));
    word_cnt_nx = word_cnt + WCW'(new_word);
    tile_end    = tc_req || ((state == REQ) && (word_cnt_nx == TOTAL_C));
    short_hit   = tc_req && (partial || (word_cnt_nx < TOTAL_C));
    start_tile  = (state == IDLE) && drain_start;
    if (accept) begin
      for (int i = 0; i < BPW; i++) begin
        if (byte_cnt == BCW'(i)) asm_nx[8*i +: 8] = data_in;
      end
    end
  end

  assign fifo_pop  = !fifo_empty && out_ready;
  assign fifo_push = pend_vld && (!fifo_full || fifo_pop);
  assign drop      = pend_vld && fifo_full && !fifo_pop;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    data_req = 1'b0;
    case (state)
      IDLE:  if (drain_start) state_nx = REQ;
      REQ: begin
        data_req = (fifo_cnt <= REQ_LIMIT);
        if (tile_end) state_nx = FLUSH;
      end
      FLUSH: if (fifo_empty && !pend_vld) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q       <= '0;
      byte_cnt    <= '0;
      word_cnt    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      pend_vld    <= 1'b0;
      pend_dat    <= '0;
      err_short_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      // One-entry stage between assembly and FIFO; a dropped word still consumes its position.
      pend_vld <= new_word;
      if (new_word) pend_dat <= {new_last, row_q, col_q, asm_nx};
      if (start_tile) begin
        asm_q       <= '0;
        byte_cnt    <= '0;
        word_cnt    <= '0;
        row_q       <= '0;
        col_q       <= '0;
        err_short_q <= 1'b0;
        err_ovf_q   <= 1'b0;
      end else begin
        if (new_word) begin
          asm_q    <= '0;
          byte_cnt <= '0;
        end else if (accept) begin
          asm_q    <= asm_nx;
          byte_cnt <= byte_cnt + 1'b1;
        end
        word_cnt <= word_cnt_nx;
        if (new_word) begin
          if (col_q == COL_MAX) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        if (short_hit) err_short_q <= 1'b1;
        if (drop)      err_ovf_q   <= 1'b1;
      end
    end
  end

  drain_word_fifo #(
    .WIDTH (FW),
    .DEPTH (WFIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (pend_dat),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (fifo_cnt),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign {out_last, out_row, out_col, out_word} = fifo_empty ? '0 : fifo_head;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign err_short    = err_short_q;
  assign err_overflow = err_ovf_q;
endmodule

// File: tb/tb_drain_word_packer.sv
// Randomized bench for drain_word_packer: byte-level stimulus, word-level reference queue, decoupled monitor.
module tb_drain_word_packer;
  localparam int ALPHA = 4;
  localparam int ADW   = 16;
  localparam int XS    = 8;
  localparam int YS    = 8;
  localparam int DEPTH = 4;
  localparam int W     = ALPHA*ADW;
  localparam int BPW   = W/8;
  localparam int TOTAL = XS*YS;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         drain_start = 1'b0;
  logic         data_valid = 1'b0;
  logic         transfer_complete = 1'b0;
  logic         out_ready = 1'b0;
  logic [7:0]   data_in = 8'h00;
  logic         data_req;
  logic [W-1:0] out_word;
  logic [2:0]   out_col;
  logic [2:0]   out_row;
  logic         out_last;
  logic         out_valid;
  logic         busy;
  logic         done;
  logic         err_short;
  logic         err_overflow;

  drain_word_packer #(
    .ALPHA(ALPHA), .ADD_DATAWIDTH(ADW), .X_SCALED(XS), .Y_SCALED(YS), .WFIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .drain_start(drain_start), .data_req(data_req),
    .data_in(data_in), .data_valid(data_valid), .transfer_complete(transfer_complete),
    .out_word(out_word), .out_col(out_col), .out_row(out_row), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .err_short(err_short), .err_overflow(err_overflow)
  );

  typedef struct {
    logic [63:0] word;
    int          row;
    int          col;
    bit          last;
  } exp_t;

  exp_t expq[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   pop_cnt = 0;
  int   last_pop_cyc = 0;
  int   first_vld_cyc = -1;
  int   ready_mode = 1;
  int   lat_ref = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t        e;
    bit          prev_stall = 0;
    logic [70:0] prev_head = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (prev_stall) begin
          check("hold_valid", 64'(out_valid), 64'(1));
          check("hold_head", 64'(prev_head[70:64]), 64'({out_last, out_row, out_col}));
          check("hold_word", out_word, prev_head[63:0]);
        end
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_word: got 0x%0h at (%0d,%0d), expected no word", out_word, out_row, out_col);
          end else begin
            e = expq.pop_front();
            check("out_word", out_word, e.word);
            check("out_pos", 64'({out_row, out_col}), 64'(e.row*YS + e.col));
            check("out_last", 64'(out_last), 64'(e.last));
          end
          pop_cnt++;
          last_pop_cyc = cyc;
        end
        prev_stall = out_valid && !out_ready;
        prev_head  = {out_last, out_row, out_col, out_word};
      end
    end
  endtask

  task automatic ready_gen();
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  // base < 0 gives random bytes; otherwise byte k = base + k*stride.
  task automatic send_word(input int pos, input int nbytes, input int base, input int stride,
                           input bit honour, input int gap_pct, input bit tc_last, input bit expect_it);
    logic [63:0] w;
    exp_t        e;
    int          b;
    int          t;
    w = '0;
    for (int k = 0; k < nbytes; k++) begin
      b = (base < 0) ? int'($urandom_range(0, 255)) : ((base + k*stride) & 255);
      while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) step();
      if (honour) begin
        t = 0;
        while (!data_req && t < 2000) begin
          step();
          t++;
        end
        if (t >= 2000) check("req_timeout", 64'(data_req), 64'(1));
      end
      data_in           = 8'(b);
      data_valid        = 1'b1;
      transfer_complete = tc_last && (k == nbytes-1);
      w[8*k +: 8]       = 8'(b);
      step();
      data_valid        = 1'b0;
      transfer_complete = 1'b0;
    end
    if (expect_it) begin
      e.word = w;
      e.row  = pos / YS;
      e.col  = pos % YS;
      e.last = (nbytes < BPW) || (pos == TOTAL-1);
      expq.push_back(e);
    end
  endtask

  task automatic start_tile();
    drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    check("errs_cleared_on_start", 64'({err_short, err_overflow}), 64'(0));
  endtask

  task automatic wait_done(input bit chk_timing);
    int t = 0;
    while (!done && t < 3000) begin
      step();
      t++;
    end
    check("done_seen", 64'(done), 64'(1));
    if (chk_timing) check("done_after_last_pop", 64'(cyc), 64'(last_pop_cyc + 2));
    step();
    check("done_one_cycle", 64'(done), 64'(0));
    check("idle_after_done", 64'(busy), 64'(0));
    check("scoreboard_drained", 64'(expq.size()), 64'(0));
  endtask

  initial begin
    int t;
    int p0;
    fork
      monitor();
      ready_gen();
    join_none

    // Reset state
    repeat (3) step();
    check("rst_flags", 64'({out_valid, busy, done, data_req, err_short, err_overflow}), 64'(0));
    check("rst_head", 64'({out_last, out_row, out_col}), 64'(0));
    check("rst_word", out_word, 64'(0));
    rst = 1'b0;
    step();

    // Bytes while idle must be ignored
    data_in = 8'h5A;
    data_valid = 1'b1;
    repeat (4) step();
    data_valid = 1'b0;
    check("idle_bytes_ignored", 64'({busy, out_valid, data_req}), 64'(0));

    // Nominal tile, sequential bytes, always ready
    ready_mode = 1;
    step();
    first_vld_cyc = -1;
    start_tile();
    for (int i = 0; i < TOTAL; i++) begin
      send_word(i, BPW, i, 1, 1'b0, 0, i == TOTAL-1, 1'b1);
      if (i == 0) lat_ref = cyc;
    end
    wait_done(1'b1);
    check("first_word_latency", 64'(first_vld_cyc), 64'(lat_ref + 1));
    check("nominal_errs", 64'({err_short, err_overflow}), 64'(0));

    // Backpressure with an upstream that honours data_req
    start_tile();
    p0 = pop_cnt;
    fork
      begin
        for (int i = 0; i < TOTAL; i++) send_word(i, BPW, -1, 0, 1'b1, 0, i == TOTAL-1, 1'b1);
      end
      begin
        t = 0;
        while (pop_cnt < p0 + 2 && t < 5000) begin
          step();
          t++;
        end
        ready_mode = 0;
        repeat (60) step();
        check("bp_req_low", 64'(data_req), 64'(0));
        check("bp_valid_held", 64'(out_valid), 64'(1));
        ready_mode = 1;
      end
    join
    wait_done(1'b0);
    check("bp_errs", 64'({err_short, err_overflow}), 64'(0));

    // Random gaps and random ready; drain_start held while busy must be ignored
    ready_mode = 2;
    start_tile();
    for (int i = 0; i < TOTAL; i++) begin
      if (i == 5) drain_start = 1'b1;
      send_word(i, BPW, -1, 0, 1'b1, 30, i == TOTAL-1, 1'b1);
      drain_start = 1'b0;
    end
    wait_done(1'b0);
    check("rand_errs", 64'({err_short, err_overflow}), 64'(0));

    // Short tile: transfer_complete after 3 bytes of word 10
    start_tile();
    for (int i = 0; i < 10; i++) send_word(i, BPW, -1, 0, 1'b1, 20, 1'b0, 1'b1);
    send_word(10, 3, 'h99, 'h11, 1'b1, 0, 1'b1, 1'b1);
    wait_done(1'b0);
    check("short_errs", 64'({err_short, err_overflow}), 64'(2));

    // Overflow: stalled output, upstream ignores data_req
    ready_mode = 0;
    step();
    start_tile();
    for (int i = 0; i < 6; i++) send_word(i, BPW, -1, 0, 1'b0, 0, 1'b0, i < DEPTH);
    repeat (3) step();
    check("ovf_flag", 64'(err_overflow), 64'(1));
    check("ovf_full_req", 64'({out_valid, data_req}), 64'(2));
    ready_mode = 1;
    t = 0;
    while (expq.size() > 0 && t < 50) begin
      step();
      t++;
    end
    check("ovf_drained", 64'(expq.size()), 64'(0));
    repeat (2) step();
    check("ovf_empty", 64'(out_valid), 64'(0));
    send_word(6, BPW, -1, 0, 1'b1, 0, 1'b0, 1'b1);
    repeat (4) step();
    transfer_complete = 1'b1;
    step();
    transfer_complete = 1'b0;
    wait_done(1'b0);
    check("ovf_errs", 64'({err_short, err_overflow}), 64'(3));

    // Reset mid-tile with buffered words, a set error flag and a partial word
    ready_mode = 1;
    start_tile();
    for (int i = 0; i < 14; i++) send_word(i, BPW, -1, 0, 1'b1, 0, 1'b0, 1'b1);
    ready_mode = 0;
    for (int i = 14; i < 20; i++) send_word(i, BPW, -1, 0, 1'b0, 0, 1'b0, 1'b0);
    send_word(20, 2, -1, 0, 1'b0, 0, 1'b0, 1'b0);
    repeat (2) step();
    check("pre_rst_ovf", 64'(err_overflow), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_flags", 64'({out_valid, busy, done, data_req, err_short, err_overflow}), 64'(0));
    expq.delete();
    ready_mode = 2;
    step();
    start_tile();
    for (int i = 0; i < TOTAL; i++) send_word(i, BPW, -1, 0, 1'b1, 10, i == TOTAL-1, 1'b1);
    ready_mode = 1;
    wait_done(1'b0);
    check("restart_errs", 64'({err_short, err_overflow}), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
